// File: rtl/ddr_wr_pkg.sv
// ddr_wr_pkg: shared types and constants for the DDR write-burst sequencer.
//   state_e     - sequencer phase (IDLE, PRE, DATA, POST)
//   DQS_IDLE    - {dqs_datain_h, dqs_datain_l} outside a data beat
//   DQS_ACTIVE  - {dqs_datain_h, dqs_datain_l} during a data beat
//   cnt_width() - phase-counter width sized for the longest phase
package ddr_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    POST = 2'd3
  } state_e;

  localparam logic [1:0] DQS_IDLE   = 2'b00;
  localparam logic [1:0] DQS_ACTIVE = 2'b10;

  // The counter holds (phase length - 1), so clog2 of the longest phase is
  // enough. A 1-bit floor keeps the vector legal when every phase is 1 cycle.
  function automatic int cnt_width(input int burst_len, input int pre_cycles,
                                   input int post_cycles);
    int max_val;
    max_val = burst_len;
    if (pre_cycles > max_val) max_val = pre_cycles;
    if (post_cycles > max_val) max_val = post_cycles;
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/ddr_wr_phase_counter.sv
// ddr_wr_phase_counter: loadable down-counter that times each sequencer phase.
//   clk, areset  - clock, synchronous active-high reset (count -> 0)
//   load_i       - load load_val_i this edge (takes priority over counting)
//   load_val_i   - phase length minus one
//   zero_o       - count is zero (last cycle of the current phase)
// The count saturates at zero so it rests there while the sequencer idles.
module ddr_wr_phase_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (areset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/ddr_write_burst_gen.sv
// ddr_write_burst_gen: write-path sequencer feeding DDIO bidir output atoms.
// Accepts write beats over wr_valid/wr_ready and frames each burst with a DQS
// preamble and postamble. All pad-side outputs are registered and map 1:1 onto
// DDIO datain_h / datain_l / oe inputs.
//   clk, areset             - clock, synchronous active-high reset
//   wr_valid/wr_ready       - beat handshake; wr_ready is high in DATA only
//   wr_data                 - [DW-1:0] rising-edge half, [2DW-1:DW] falling half
//   dq_datain_h/_l, dq_oe   - DQ pad data halves and output enable
//   dqs_datain_h/_l, dqs_oe - DQS pad data halves and output enable
//   busy                    - sequencer is not idle
//   underrun                - sticky: a DATA slot passed with wr_valid low
// Build option DDR_WR_SEAMLESS_EN: when the last beat of a burst sees wr_valid
// high, the next burst follows immediately with no postamble/preamble gap.
module ddr_write_burst_gen
  import ddr_wr_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int BURST_LEN        = 4,
  parameter int PREAMBLE_CYCLES  = 1,
  parameter int POSTAMBLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [2*DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0]   dq_datain_h,
  output logic [DATA_WIDTH-1:0]   dq_datain_l,
  output logic                    dq_oe,
  output logic                    dqs_datain_h,
  output logic                    dqs_datain_l,
  output logic                    dqs_oe,
  output logic                    busy,
  output logic                    underrun
);

  localparam int CNT_W = cnt_width(BURST_LEN, PREAMBLE_CYCLES, POSTAMBLE_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_PRE  = CNT_W'(PREAMBLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_DATA = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LOAD_POST = CNT_W'(POSTAMBLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_zero;

  logic [DATA_WIDTH-1:0] dq_h_q, dq_h_d;
  logic [DATA_WIDTH-1:0] dq_l_q, dq_l_d;
  logic                  dq_oe_q, dq_oe_d;
  logic [1:0]            dqs_q, dqs_d;
  logic                  dqs_oe_q, dqs_oe_d;
  logic                  underrun_q, underrun_d;

  ddr_wr_phase_counter #(
    .WIDTH(CNT_W)
  ) u_phase_cnt (
    .clk        (clk),
    .areset     (areset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // Phase sequencing: the counter is reloaded on every state entry and
  // otherwise counts down; zero marks the last cycle of the phase.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          state_d      = PRE;
          cnt_load     = 1'b1;
          cnt_load_val = LOAD_PRE;
        end
      end
      PRE: begin
        if (cnt_zero) begin
          state_d      = DATA;
          cnt_load     = 1'b1;
          cnt_load_val = LOAD_DATA;
        end
      end
      DATA: begin
        if (cnt_zero) begin
`ifdef DDR_WR_SEAMLESS_EN
          if (wr_valid) begin
            // Chain straight into the next burst; strobes stay enabled.
            cnt_load     = 1'b1;
            cnt_load_val = LOAD_DATA;
          end else begin
            state_d      = POST;
            cnt_load     = 1'b1;
            cnt_load_val = LOAD_POST;
          end
`else
          state_d      = POST;
          cnt_load     = 1'b1;
          cnt_load_val = LOAD_POST;
`endif
        end
      end
      POST: begin
        if (cnt_zero) begin
          state_d      = IDLE;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad-side values for the next edge, decoded from the current state.
  // A DATA slot is consumed whether or not a beat is offered; a missing beat
  // drives zeros and latches underrun.
  always_comb begin
    dq_h_d     = '0;
    dq_l_d     = '0;
    dq_oe_d    = 1'b0;
    dqs_d      = DQS_IDLE;
    dqs_oe_d   = 1'b0;
    underrun_d = underrun_q;
    case (state_q)
      PRE, POST: begin
        dqs_oe_d = 1'b1;
      end
      DATA: begin
        dq_oe_d  = 1'b1;
        dqs_oe_d = 1'b1;
        dqs_d    = DQS_ACTIVE;
        if (wr_valid) begin
          dq_h_d = wr_data[DATA_WIDTH-1:0];
          dq_l_d = wr_data[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
          underrun_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset abandons any burst in flight: all pads drop at once, no postamble.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= IDLE;
      dq_h_q     <= '0;
      dq_l_q     <= '0;
      dq_oe_q    <= 1'b0;
      dqs_q      <= DQS_IDLE;
      dqs_oe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dq_h_q     <= dq_h_d;
      dq_l_q     <= dq_l_d;
      dq_oe_q    <= dq_oe_d;
      dqs_q      <= dqs_d;
      dqs_oe_q   <= dqs_oe_d;
      underrun_q <= underrun_d;
    end
  end

  assign wr_ready     = (state_q == DATA);
  assign busy         = (state_q != IDLE);
  assign dq_datain_h  = dq_h_q;
  assign dq_datain_l  = dq_l_q;
  assign dq_oe        = dq_oe_q;
  assign dqs_datain_h = dqs_q[1];
  assign dqs_datain_l = dqs_q[0];
  assign dqs_oe       = dqs_oe_q;
  assign underrun     = underrun_q;

endmodule
